// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the RV32I core.
// Walks each instruction through FETCH, DECODE, EXEC, then MEM or STDIO
// when needed, and finally WB. It turns the decoder's level enables into
// single-cycle write strobes and stalls on instruction fetch, RAM read
// latency and the stdin/stdout handshakes.
module cpu_sequencer #(
   parameter int unsigned RAM_READ_LATENCY = 2,
   parameter logic [1:0]  REG_SRC_RAM      = 2'd1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        run,
   input  logic        imem_valid,
   input  logic        dec_reg_write_enable,
   input  logic        dec_ram_write_enable,
   input  logic [1:0]  dec_reg_write_data_src,
   input  logic        dec_stdin_read_enable,
   input  logic        dec_stdout_write_enable,
   input  logic        stdin_valid,
   input  logic        stdout_ready,
   output logic        imem_req,
   output logic        ir_we,
   output logic        reg_we,
   output logic        ram_we,
   output logic        stdin_ack,
   output logic        stdout_valid,
   output logic        pc_we,
   output logic        retire,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_STDIO  = 3'd5,
      S_WB     = 3'd6
   } state_t;

   // Read latency fits the 4-bit countdown (legal range 1..15).
   localparam logic [3:0] LAT = 4'(RAM_READ_LATENCY);

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  lat_cnt_q;
   logic [31:0] instret_q;

   logic is_store;
   logic is_load;
   logic is_stdio;

   assign is_store = dec_ram_write_enable;
   assign is_load  = (dec_reg_write_data_src == REG_SRC_RAM);
   assign is_stdio = dec_stdin_read_enable | dec_stdout_write_enable;

   assign state   = state_q;
   assign instret = instret_q;

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // RAM read latency countdown: armed on the EXEC->MEM transition,
   // counts down while in MEM so a load leaves MEM when it reaches 1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lat_cnt_q <= 4'd0;
      end else if (state_q == S_EXEC && state_d == S_MEM) begin
         lat_cnt_q <= LAT;
      end else if (state_q == S_MEM && lat_cnt_q != 4'd0) begin
         lat_cnt_q <= lat_cnt_q - 4'd1;
      end
   end

   // Retired-instruction counter, bumped once per WB cycle, wraps at 2^32.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         instret_q <= 32'd0;
      end else if (state_q == S_WB) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   // Next-state selection and strobe generation; every strobe is tied to
   // the single state that owns it so it cannot leak into other states.
   always_comb begin
      state_d      = state_q;
      imem_req     = 1'b0;
      ir_we        = 1'b0;
      reg_we       = 1'b0;
      ram_we       = 1'b0;
      stdin_ack    = 1'b0;
      stdout_valid = 1'b0;
      pc_we        = 1'b0;
      retire       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_valid) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_stdio) begin
               state_d = S_STDIO;
            end else if (is_store || is_load) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            // A store is always a single MEM cycle, and wins over a load
            // if the decoder flags both.
            if (is_store) begin
               ram_we  = 1'b1;
               state_d = S_WB;
            end else if (lat_cnt_q <= 4'd1) begin
               state_d = S_WB;
            end
         end
         S_STDIO: begin
            if (dec_stdin_read_enable) begin
               if (stdin_valid) begin
                  stdin_ack = 1'b1;
                  state_d   = S_WB;
               end
            end else if (dec_stdout_write_enable) begin
               stdout_valid = 1'b1;
               if (stdout_ready) state_d = S_WB;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            reg_we  = dec_reg_write_enable;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven and randomized check of cpu_sequencer
// against cycle counts and strobe counts derived from the instruction class.
module tb_cpu_sequencer;

   localparam int LAT = 3;
   localparam logic [1:0] SRC_RAM = 2'd1;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        run = 1'b0;
   logic        imem_valid = 1'b0;
   logic        dec_rwe = 1'b0;
   logic        dec_mwe = 1'b0;
   logic [1:0]  dec_src = 2'd0;
   logic        dec_sin = 1'b0;
   logic        dec_sout = 1'b0;
   logic        stdin_valid = 1'b0;
   logic        stdout_ready = 1'b0;
   logic        imem_req, ir_we, reg_we, ram_we, stdin_ack, stdout_valid;
   logic        pc_we, retire;
   logic [2:0]  st;
   logic [31:0] instret;

   cpu_sequencer #(.RAM_READ_LATENCY(LAT), .REG_SRC_RAM(SRC_RAM)) dut (
      .clk(clk), .rstn(rstn), .run(run), .imem_valid(imem_valid),
      .dec_reg_write_enable(dec_rwe), .dec_ram_write_enable(dec_mwe),
      .dec_reg_write_data_src(dec_src), .dec_stdin_read_enable(dec_sin),
      .dec_stdout_write_enable(dec_sout), .stdin_valid(stdin_valid),
      .stdout_ready(stdout_ready), .imem_req(imem_req), .ir_we(ir_we),
      .reg_we(reg_we), .ram_we(ram_we), .stdin_ack(stdin_ack),
      .stdout_valid(stdout_valid), .pc_we(pc_we), .retire(retire),
      .state(st), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rwe;
      logic       mwe;
      logic [1:0] src;
      logic       sin;
      logic       sout;
      int         d_imem;
      int         wt;
      int         exp_cyc;
      int         exp_ram;
      int         exp_ack;
      int         exp_sov;
   } vec_t;

   int total = 0;
   int bad = 0;
   logic [31:0] model_instret = 32'd0;

   int m_cyc, m_ram, m_ack, m_sov, m_reg, m_ir, m_pc, m_ret, m_viol, m_to;
   int m_states[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rwe, input logic mwe, input logic [1:0] src,
                               input logic sin, input logic sout, input int d_imem,
                               input int wt, input int cyc, input int ram,
                               input int ack, input int sov);
      vec_t v;
      v.rwe = rwe; v.mwe = mwe; v.src = src; v.sin = sin; v.sout = sout;
      v.d_imem = d_imem; v.wt = wt; v.exp_cyc = cyc; v.exp_ram = ram;
      v.exp_ack = ack; v.exp_sov = sov;
      return v;
   endfunction

   // Reference model: cost of an instruction from its class, plain arithmetic.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int extra;
      if (v.sin || v.sout) extra = v.wt + 1;
      else if (v.mwe) extra = 1;
      else if (v.src == SRC_RAM) extra = LAT;
      else extra = 0;
      r.exp_cyc = (v.d_imem + 1) + 1 + 1 + extra + 1;
      r.exp_ram = (!(v.sin || v.sout) && v.mwe) ? 1 : 0;
      r.exp_ack = v.sin ? 1 : 0;
      r.exp_sov = (!v.sin && v.sout) ? v.wt + 1 : 0;
      return r;
   endfunction

   // Drive one instruction starting at a negedge in FETCH; acts as the
   // instruction memory and stdio peers, and tallies strobes per cycle.
   task automatic run_instr(input vec_t v, input bit drop_run);
      int fetch_n = 0;
      int stdio_n = 0;
      bit done = 0;
      m_cyc = 0; m_ram = 0; m_ack = 0; m_sov = 0; m_reg = 0; m_ir = 0;
      m_pc = 0; m_ret = 0; m_viol = 0; m_to = 0;
      m_states.delete();
      dec_rwe = v.rwe; dec_mwe = v.mwe; dec_src = v.src;
      dec_sin = v.sin; dec_sout = v.sout;
      for (int c = 0; c < 100 && !done; c++) begin
         imem_valid   = (st == 3'd1) && (fetch_n >= v.d_imem);
         stdin_valid  = (st == 3'd5) && (stdio_n >= v.wt);
         stdout_ready = (st == 3'd5) && (stdio_n >= v.wt);
         if (drop_run && st == 3'd3) run = 1'b0;
         #1;
         m_cyc++;
         m_states.push_back(int'(st));
         if (ram_we) m_ram++;
         if (stdin_ack) m_ack++;
         if (stdout_valid) m_sov++;
         if (reg_we) m_reg++;
         if (ir_we) m_ir++;
         if (pc_we) m_pc++;
         if (retire) m_ret++;
         if ((reg_we && st != 3'd6) || (pc_we && st != 3'd6) ||
             (ram_we && st != 3'd4) || (stdin_ack && st != 3'd5) ||
             (ir_we && st != 3'd1)) m_viol++;
         if (st == 3'd1) fetch_n++;
         if (st == 3'd5) stdio_n++;
         if (retire) done = 1;
         @(negedge clk);
      end
      if (!done) m_to = 1;
      dec_rwe = 0; dec_mwe = 0; dec_src = 0; dec_sin = 0; dec_sout = 0;
      imem_valid = 0; stdin_valid = 0; stdout_ready = 0;
   endtask

   task automatic check_vec(input string nm, input vec_t v, input bit drop_run);
      run_instr(v, drop_run);
      model_instret = model_instret + 32'd1;
      chk({nm, "_timeout"}, m_to, 0);
      chk({nm, "_cycles"}, m_cyc, v.exp_cyc);
      chk({nm, "_ram_we"}, m_ram, v.exp_ram);
      chk({nm, "_stdin_ack"}, m_ack, v.exp_ack);
      chk({nm, "_stdout_valid"}, m_sov, v.exp_sov);
      chk({nm, "_reg_we"}, m_reg, v.rwe ? 1 : 0);
      chk({nm, "_ir_we"}, m_ir, 1);
      chk({nm, "_pc_we"}, m_pc, 1);
      chk({nm, "_retire"}, m_ret, 1);
      chk({nm, "_misplaced"}, m_viol, 0);
      chk({nm, "_instret"}, instret, model_instret);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[10];
      vec_t rv;
      int seq_exp[4];
      int n;
      seq_exp = '{1, 2, 3, 6};

      tbl[0] = mk(1, 0, 2'd0, 0, 0, 0, 0, 4, 0, 0, 0);   // ADD
      tbl[1] = mk(0, 1, 2'd0, 0, 0, 0, 0, 5, 1, 0, 0);   // store
      tbl[2] = mk(1, 0, 2'd1, 0, 0, 0, 0, 7, 0, 0, 0);   // load, latency 3
      tbl[3] = mk(0, 0, 2'd0, 0, 1, 0, 5, 10, 0, 0, 6);  // stdout, ready after 5
      tbl[4] = mk(1, 0, 2'd0, 1, 0, 0, 3, 8, 0, 1, 0);   // stdin, valid after 3
      tbl[5] = mk(1, 0, 2'd0, 1, 1, 0, 2, 7, 0, 1, 0);   // both stdio flags
      tbl[6] = mk(0, 1, 2'd1, 0, 0, 0, 0, 5, 1, 0, 0);   // store+load fault
      tbl[7] = mk(0, 1, 2'd0, 0, 1, 0, 0, 5, 0, 0, 1);   // stdio beats store
      tbl[8] = mk(1, 0, 2'd0, 0, 0, 3, 0, 7, 0, 0, 0);   // slow fetch
      tbl[9] = mk(1, 0, 2'd2, 0, 0, 0, 0, 4, 0, 0, 0);   // non-RAM source

      // Reset state
      #1 rstn = 1'b0;
      #2;
      chk("rst_state", st, 3'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_strobes", {imem_req, ir_we, reg_we, ram_we, stdin_ack,
                          stdout_valid, pc_we, retire}, 8'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_no_run", st, 3'd0);
      chk("idle_no_req", imem_req, 1'b0);
      run = 1'b1;
      @(negedge clk);
      chk("run_to_fetch", st, 3'd1);

      // Table vectors
      for (int i = 0; i < 10; i++) begin
         check_vec($sformatf("tbl%0d", i), tbl[i], 1'b0);
         if (i == 0) begin
            for (int k = 0; k < 4; k++)
               chk($sformatf("add_seq%0d", k), (k < m_states.size()) ? m_states[k] : -1,
                   seq_exp[k]);
         end
         chk($sformatf("tbl%0d_next", i), st, 3'd1);
      end

      // Reset in the middle of a load's MEM phase
      dec_rwe = 1; dec_src = SRC_RAM; imem_valid = 1'b1;
      n = 0;
      while (st != 3'd4 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_mem", st, 3'd4);
      imem_valid = 1'b0;
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("midmem_state", st, 3'd0);
      chk("midmem_instret", instret, 32'd0);
      chk("midmem_strobes", {imem_req, ir_we, reg_we, ram_we, stdin_ack,
                             stdout_valid, pc_we, retire}, 8'd0);
      dec_rwe = 0; dec_src = 0;
      model_instret = 32'd0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_fetch", st, 3'd1);

      // Drop run during EXEC: instruction still completes, then IDLE
      check_vec("droprun", tbl[0], 1'b1);
      chk("droprun_idle", st, 3'd0);
      chk("droprun_noreq", imem_req, 1'b0);
      @(negedge clk);
      chk("droprun_stay", st, 3'd0);

      // instret wrap
      force dut.instret_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.instret_q;
      @(negedge clk);
      chk("wrap_preset", instret, 32'hFFFF_FFFF);
      model_instret = 32'hFFFF_FFFF;
      run = 1'b1;
      @(negedge clk);
      chk("wrap_fetch", st, 3'd1);
      check_vec("wrap", tbl[0], 1'b0);
      chk("wrap_zero", instret, 32'd0);

      // Randomized instruction stream against the model
      for (int i = 0; i < 40; i++) begin
         rv.rwe = 1'($urandom_range(0, 1));
         rv.src = 2'($urandom_range(0, 3));
         rv.mwe = 1'($urandom_range(0, 3) == 0);
         rv.sin = 1'($urandom_range(0, 4) == 0);
         rv.sout = 1'($urandom_range(0, 4) == 0);
         rv.d_imem = int'($urandom_range(0, 3));
         rv.wt = int'($urandom_range(0, 4));
         rv = model(rv);
         check_vec($sformatf("rnd%0d", i), rv, 1'b0);
      end
      chk("final_instret", instret, model_instret);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory, stdio and writeback around the combinational instruction decoder. It converts the decoder's level enables into single-cycle write strobes, and stalls on instruction memory, data RAM read latency and the stdin/stdout handshakes. It sits between the decoder, the PC register, the instruction register, the register file, the data RAM and the UART stdio bridge.

Parameters:
RAM_READ_LATENCY, 2, cycles from address valid to RAM read data valid; legal range 1..15.
REG_SRC_RAM, 2'd1, value of dec_reg_write_data_src that selects RAM read data (identifies loads).

Ports:
clk  input  1  core clock
rstn  input  1  asynchronous active-low reset
run  input  1  1 = execute instructions; sampled in IDLE and WB only
imem_valid  input  1  instruction word valid this cycle
dec_reg_write_enable  input  1  decoder register-write enable
dec_ram_write_enable  input  1  decoder RAM-write enable
dec_reg_write_data_src  input  2  decoder writeback source select
dec_stdin_read_enable  input  1  decoder stdin instruction flag
dec_stdout_write_enable  input  1  decoder stdout instruction flag
stdin_valid  input  1  stdin byte available
stdout_ready  input  1  stdout bridge can accept a byte
imem_req  output  1  instruction fetch request
ir_we  output  1  instruction register load strobe
reg_we  output  1  register-file write strobe
ram_we  output  1  data RAM write strobe
stdin_ack  output  1  stdin byte consumed; also the stdin data latch enable
stdout_valid  output  1  stdout byte offered
pc_we  output  1  PC update strobe
retire  output  1  instruction completed
state  output  3  current FSM state, for debug
instret  output  32  retired-instruction counter

Behaviour:
- Reset: asynchronous on rstn=0. State goes to IDLE, instret to 0, the latency counter to 0, and every output to 0 immediately. Reset mid-instruction abandons the instruction with no strobes issued.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, STDIO=5, WB=6. Value 7 is illegal and goes to IDLE on the next edge.
- IDLE: all outputs 0. If run=1, go to FETCH.
- FETCH: imem_req=1 and is held until imem_valid. In the cycle imem_valid=1, ir_we=1 for exactly that cycle, and the next state is DECODE.
- DECODE: 1 cycle, for register read and decoder settling. Go to EXEC.
- EXEC: 1 cycle, for the ALU. The next state is chosen by priority:
  - 1. dec_stdin_read_enable or dec_stdout_write_enable: go to STDIO.
  - 2. dec_ram_write_enable, or dec_reg_write_data_src==REG_SRC_RAM: go to MEM.
  - 3. Otherwise: go to WB.
- MEM, store: ram_we=1 on the first MEM cycle only, then go to WB. This takes 1 cycle.
- MEM, load: the counter is loaded with RAM_READ_LATENCY on entry and decrements each cycle. Go to WB when it reaches 1, so MEM lasts exactly RAM_READ_LATENCY cycles. ram_we stays 0.
- If a decoder fault asserts both the store and load conditions, store wins.
- STDIO, stdin (priority over stdout if both flags are set): wait while stdin_valid=0. In the first cycle with stdin_valid=1, stdin_ack=1 for one cycle, then go to WB.
- STDIO, stdout: stdout_valid=1 is held until stdout_ready=1. The handshake completes in the cycle where both are 1; then go to WB. stdout_valid is never withdrawn before the handshake completes.
- WB: 1 cycle. reg_we=dec_reg_write_enable, pc_we=1, retire=1, and instret increments by 1, wrapping at 2^32 (0xFFFFFFFF goes to 0). Next state is FETCH if run=1, else IDLE.
- Strobes ir_we, ram_we, stdin_ack, pc_we and retire are each exactly 1 cycle wide per instruction.
- reg_we, ram_we, stdin_ack and pc_we are never asserted outside WB, MEM or STDIO respectively.
- Decoder inputs are sampled only in EXEC, MEM, STDIO and WB. In those states the IR is stable, so the decoder outputs are stable.
- Deasserting run mid-instruction has no effect until WB; the instruction always completes.
- Cycles per instruction with immediate imem_valid:
  - ALU, branch and jump: 4 (FETCH, DECODE, EXEC, WB).
  - Store: 5.
  - Load: 4+RAM_READ_LATENCY.
  - Stdio: 5 plus any wait cycles.

Test Plan:
- ADD, imem_valid immediate, run=1: state sequence 1,2,3,6,1. reg_we=1 and pc_we=1 only in the WB cycle. instret 0→1. retire is 1 for one cycle.
- Store (dec_ram_write_enable=1, dec_reg_write_enable=0): ram_we=1 for exactly one cycle in MEM. reg_we=0 in WB. 5 cycles FETCH-to-FETCH.
- Load with RAM_READ_LATENCY=3 (dec_reg_write_data_src=REG_SRC_RAM): MEM lasts 3 cycles, then WB with reg_we=1. Total 7 cycles.
- Stdout with stdout_ready held 0 for 5 cycles then 1: stdout_valid stays 1 for 6 cycles, then WB. Stdin with stdin_valid arriving after 3 cycles: stdin_ack is one pulse, then WB with reg_we=1.
- Assert rstn=0 mid-MEM: state=0, instret=0 and all strobes 0 immediately with no ram_we. After release with run=1, the next cycle is FETCH.
- Force instret to 0xFFFFFFFF, retire one instruction: instret=0. Drop run during EXEC: the instruction completes with WB, then IDLE with imem_req=0.
